// File: rtl/mem_cmd_bridge.sv
// Responder bridge from the memory-test command handshake onto a single-beat Avalon-MM master.
// Tracks completed transactions and sticky error conditions for the register block.
module mem_cmd_bridge #(
    parameter int          ADDR_WIDTH = 64,
    parameter int          WORD_WIDTH = 64,
    parameter int          TIMEOUT    = 1024,
    // Reset value of both transaction counters; nonzero only to exercise saturation.
    parameter logic [31:0] CNT_INIT   = 32'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] gen_address,
    input  logic [WORD_WIDTH-1:0] gen_word,
    input  logic                  write,
    output logic                  confirm,
    output logic [WORD_WIDTH-1:0] pattern_rb,
    output logic [ADDR_WIDTH-1:0] avl_addr,
    output logic [WORD_WIDTH-1:0] avl_wdata,
    output logic                  avl_write_req,
    output logic                  avl_read_req,
    output logic                  avl_burstbegin,
    input  logic                  avl_ready,
    input  logic                  avl_rdata_valid,
    input  logic [WORD_WIDTH-1:0] avl_rdata,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  spurious_err,
    output logic [31:0]           wr_count,
    output logic [31:0]           rd_count,
    output logic [1:0]            bridge_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t                state_r;
    logic                  wr_flag_r;
    logic [15:0]           to_cnt_r;
    logic                  confirm_r;
    logic [WORD_WIDTH-1:0] pattern_rb_r;
    logic [ADDR_WIDTH-1:0] avl_addr_r;
    logic [WORD_WIDTH-1:0] avl_wdata_r;
    logic                  avl_write_req_r;
    logic                  avl_read_req_r;
    logic                  timeout_err_r;
    logic                  spurious_err_r;
    logic [31:0]           wr_count_r;
    logic [31:0]           rd_count_r;

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            return val;
        end else begin
            return val + 32'd1;
        end
    endfunction

    // Command FSM with all registered outputs, counters and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            wr_flag_r       <= 1'b0;
            to_cnt_r        <= 16'd0;
            confirm_r       <= 1'b0;
            pattern_rb_r    <= '0;
            avl_addr_r      <= '0;
            avl_wdata_r     <= '0;
            avl_write_req_r <= 1'b0;
            avl_read_req_r  <= 1'b0;
            timeout_err_r   <= 1'b0;
            spurious_err_r  <= 1'b0;
            wr_count_r      <= CNT_INIT;
            rd_count_r      <= CNT_INIT;
        end else begin
            confirm_r <= 1'b0;
            // Read data arriving when no read is outstanding is dropped and flagged.
            if (avl_rdata_valid && (state_r != ST_WAIT_RD)) begin
                spurious_err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        avl_addr_r      <= gen_address;
                        avl_wdata_r     <= gen_word;
                        wr_flag_r       <= write;
                        avl_write_req_r <= write;
                        avl_read_req_r  <= ~write;
                        state_r         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (avl_ready) begin
                        avl_write_req_r <= 1'b0;
                        avl_read_req_r  <= 1'b0;
                        to_cnt_r        <= 16'd0;
                        if (wr_flag_r) begin
                            confirm_r  <= 1'b1;
                            wr_count_r <= sat_inc(wr_count_r);
                            state_r    <= ST_DONE;
                        end else begin
                            state_r <= ST_WAIT_RD;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    to_cnt_r <= to_cnt_r + 16'd1;
                    // Valid data takes priority over a timeout landing in the same cycle.
                    if (avl_rdata_valid) begin
                        pattern_rb_r <= avl_rdata;
                        confirm_r    <= 1'b1;
                        rd_count_r   <= sat_inc(rd_count_r);
                        state_r      <= ST_DONE;
                    end else if (to_cnt_r == TO_LAST) begin
                        pattern_rb_r  <= '0;
                        timeout_err_r <= 1'b1;
                        confirm_r     <= 1'b1;
                        rd_count_r    <= sat_inc(rd_count_r);
                        state_r       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    avl_write_req_r <= 1'b0;
                    avl_read_req_r  <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

    assign confirm        = confirm_r;
    assign pattern_rb     = pattern_rb_r;
    assign avl_addr       = avl_addr_r;
    assign avl_wdata      = avl_wdata_r;
    assign avl_write_req  = avl_write_req_r;
    assign avl_read_req   = avl_read_req_r;
    assign avl_burstbegin = avl_write_req_r | avl_read_req_r;
    assign busy           = (state_r != ST_IDLE);
    assign timeout_err    = timeout_err_r;
    assign spurious_err   = spurious_err_r;
    assign wr_count       = wr_count_r;
    assign rd_count       = rd_count_r;
    assign bridge_state   = state_r;

endmodule

// File: doc/mem_cmd_bridge.md
# mem_cmd_bridge

Responder side of the memory-test command interface. Accepts one read or write command at a time from the memory-test state machine (address, word, write flag), issues it to the Stratix V DDR controller's Avalon-MM local interface, and returns a one-cycle `confirm` pulse with read-back data in `pattern_rb` once the command completes. Sits between the test state machine and the UniPHY controller; also keeps transaction counters and error flags for the register block.

## Interface
- `ADDR_WIDTH`, default 64: command and Avalon address width in bits.
- `WORD_WIDTH`, default 64: data word width in bits.
- `TIMEOUT`, default 1024: maximum cycles in WAIT_RD before abort; legal range 2..65535.

Ports:
- `clk` input, 1 bit: single clock for all logic, including the Avalon side.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `req_valid` input, 1 bit: command present on `gen_address`, `gen_word` and `write`.
- `gen_address` input, ADDR_WIDTH bits: target address.
- `gen_word` input, WORD_WIDTH bits: write data.
- `write` input, 1 bit: 1 = write, 0 = read.
- `confirm` output, 1 bit: one-cycle completion pulse.
- `pattern_rb` output, WORD_WIDTH bits: data from the last completed read.
- `avl_addr` output, ADDR_WIDTH bits: Avalon address.
- `avl_wdata` output, WORD_WIDTH bits: Avalon write data.
- `avl_write_req` output, 1 bit: Avalon write request.
- `avl_read_req` output, 1 bit: Avalon read request.
- `avl_burstbegin` output, 1 bit: equals `avl_write_req | avl_read_req`; burst size is always 1.
- `avl_ready` input, 1 bit: controller accepts the request this cycle.
- `avl_rdata_valid` input, 1 bit: `avl_rdata` is valid.
- `avl_rdata` input, WORD_WIDTH bits: read data.
- `busy` output, 1 bit: state is not IDLE.
- `timeout_err` output, 1 bit: sticky; a read timed out.
- `spurious_err` output, 1 bit: sticky; `avl_rdata_valid` was seen outside WAIT_RD.
- `wr_count` output, 32 bits: completed writes, saturating.
- `rd_count` output, 32 bits: completed reads (including timed-out reads), saturating.
- `bridge_state` output, 2 bits: IDLE=0, ISSUE=1, WAIT_RD=2, DONE=3.

## Operation
- Reset values: state IDLE; all outputs 0, including `pattern_rb`, the counters and the error flags.
- IDLE: when `req_valid`=1, latch `gen_address`, `gen_word` and `write` into internal registers and go to ISSUE. Otherwise stay.
- ISSUE:
  - Drive `avl_addr`/`avl_wdata` from the latched registers.
  - Assert `avl_write_req` if the latched write flag is 1, else `avl_read_req`. Never both.
  - Hold the request and all Avalon outputs stable until `avl_ready`=1.
  - On the accepting cycle: a write goes to DONE; a read goes to WAIT_RD and clears the timeout counter.
- WAIT_RD:
  - Increment the 16-bit timeout counter every cycle.
  - On `avl_rdata_valid`=1, register `avl_rdata` into `pattern_rb` and go to DONE.
  - If the counter reaches TIMEOUT-1 with no valid, set `timeout_err`, load `pattern_rb` with all zeros, and go to DONE.
  - If valid and timeout occur in the same cycle, valid wins: data is captured and no error is raised.
- DONE: `confirm`=1 for exactly this cycle. Increment `wr_count` or `rd_count`, holding at 0xFFFFFFFF. Return to IDLE. `req_valid` is ignored in DONE.
- Inputs `gen_*`/`write` are sampled only in IDLE; later changes do not affect the command in flight.
- `avl_rdata_valid` in any state other than WAIT_RD: the data is discarded, `spurious_err` is set, and `pattern_rb` is unchanged.
- Avalon request outputs are 0 in every state except ISSUE. `avl_addr`/`avl_wdata` hold their last value.
- `pattern_rb` changes only on a read completion; it is stable between reads.
- Sticky errors and counters clear only on `reset`.

## Timing
- All outputs are registered except `avl_burstbegin`, `busy` and `bridge_state`, which are decoded from registered state.
- Write, `avl_ready` held high: `req_valid` sampled at cycle 0 → request high at cycle 1 → `confirm` at cycle 2 → IDLE at cycle 3. Minimum turnaround is 3 cycles.
- Read: request at cycle 1, accepted at cycle a; `avl_rdata_valid` at cycle v > a → `pattern_rb` updated and `confirm` high at cycle v+1.
- Back-to-back: if `req_valid` stays high, the next command is latched in the IDLE cycle following DONE.
- Asynchronous `reset` mid-transaction: requests drop immediately, `confirm` is not issued, and a late `avl_rdata_valid` after reset release sets `spurious_err`.

## Test plan
- Write, `avl_ready`=1: addr=0x400, word=0xA5A5A5A5A5A5A5A5 → `avl_write_req` high for 1 cycle with those values; `confirm` at cycle 2; `wr_count`=1.
- Read with ready stall: `avl_ready` low for 5 cycles → request and address held stable for 6 cycles; `rdata_valid` with 0x5A5A... 4 cycles after accept → `pattern_rb`=0x5A5A..., one `confirm` pulse; `rd_count`=1.
- Timeout with TIMEOUT=8 and no valid → `confirm` exactly 8 cycles after WAIT_RD entry; `timeout_err`=1; `pattern_rb`=0.
- Stray `avl_rdata_valid` during IDLE with 0xFFFF... → `spurious_err`=1, `pattern_rb` unchanged, no `confirm`.
- 1024 back-to-back writes with `req_valid` held high → 1024 `confirm` pulses spaced 3 cycles apart; `wr_count`=1024. Counter preloaded near the limit saturates at 0xFFFFFFFF.
- Asynchronous `reset` asserted in WAIT_RD → all outputs 0 within the same cycle; state IDLE after release.
